// File: rtl/fetch_controller.sv
// Fetch sequencer: boots after reset, drives imem requests and PC stall/redirect, and
// parks redirects while an imem request is still outstanding.
module fetch_controller #(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      pc_i,
   input  logic             hazard_stall_i,
   input  logic             ex_branch_taken_i,
   input  logic [31:0]      ex_branch_target_i,
   input  logic             id_jump_i,
   input  logic [31:0]      id_jump_target_i,
   input  logic             exc_req_i,
   input  logic [31:0]      exc_pc_i,
   input  logic             imem_ready_i,
   output logic             imem_req_o,
   output logic [31:0]      imem_addr_o,
   output logic             pc_stall_o,
   output logic             pc_redirect_o,
   output logic [31:0]      pc_target_o,
   output logic             flush_if_o,
   output logic             flush_id_o,
   output logic [31:0]      epc_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BootW-1:0] BootLast = BootW'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StBoot, StFetch, StDrain} state_e;
   // Encoded so that a numerically larger kind has higher priority.
   typedef enum logic [1:0] {KindNone, KindJump, KindBranch, KindExc} kind_e;

   state_e            state_q, state_d;
   logic [BootW-1:0]  boot_cnt_q, boot_cnt_d;
   kind_e             pend_kind_q, pend_kind_d;
   logic [31:0]       pend_tgt_q, pend_tgt_d;
   logic [31:0]       epc_q, epc_d;
   logic [31:0]       last_tgt_q, last_tgt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   kind_e       new_kind, sel_kind, issue_kind;
   logic [31:0] new_tgt, sel_tgt, issue_tgt;
   logic        issue;

   always_comb begin
      new_kind = KindNone;
      new_tgt  = '0;
      if (exc_req_i) begin
         new_kind = KindExc;
         new_tgt  = TRAP_VECTOR;
      end else if (ex_branch_taken_i) begin
         new_kind = KindBranch;
         new_tgt  = ex_branch_target_i;
      end else if (id_jump_i) begin
         new_kind = KindJump;
         new_tgt  = id_jump_target_i;
      end
   end

   // Pending redirect is replaced only by a strictly higher-priority request.
   always_comb begin
      sel_kind = pend_kind_q;
      sel_tgt  = pend_tgt_q;
      if (new_kind > pend_kind_q) begin
         sel_kind = new_kind;
         sel_tgt  = new_tgt;
      end
   end

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      pend_kind_d   = pend_kind_q;
      pend_tgt_d    = pend_tgt_q;
      epc_d         = epc_q;
      last_tgt_d    = last_tgt_q;
      cnt_d         = cnt_q;
      imem_req_o    = 1'b0;
      pc_stall_o    = 1'b1;
      pc_redirect_o = 1'b0;
      flush_if_o    = 1'b0;
      flush_id_o    = 1'b0;
      issue         = 1'b0;
      issue_kind    = KindNone;
      issue_tgt     = '0;

      unique case (state_q)
         StBoot: begin
            if (boot_cnt_q == BootLast) begin
               state_d    = StFetch;
               boot_cnt_d = '0;
            end else begin
               boot_cnt_d = boot_cnt_q + 1'b1;
            end
         end
         StFetch: begin
            imem_req_o = 1'b1;
            if (new_kind != KindNone) begin
               if (new_kind == KindExc) epc_d = exc_pc_i;
               if (imem_ready_i) begin
                  issue      = 1'b1;
                  issue_kind = new_kind;
                  issue_tgt  = new_tgt;
               end else begin
                  pend_kind_d = new_kind;
                  pend_tgt_d  = new_tgt;
                  state_d     = StDrain;
               end
            end else begin
               pc_stall_o = !imem_ready_i || hazard_stall_i;
            end
         end
         StDrain: begin
            imem_req_o  = 1'b1;
            pend_kind_d = sel_kind;
            pend_tgt_d  = sel_tgt;
            if (new_kind == KindExc && pend_kind_q != KindExc) epc_d = exc_pc_i;
            if (imem_ready_i) begin
               issue       = 1'b1;
               issue_kind  = sel_kind;
               issue_tgt   = sel_tgt;
               pend_kind_d = KindNone;
               state_d     = StFetch;
            end
         end
         default: state_d = StBoot;
      endcase

      if (issue) begin
         pc_redirect_o = 1'b1;
         pc_stall_o    = 1'b0;
         flush_if_o    = 1'b1;
         flush_id_o    = (issue_kind == KindExc) || (issue_kind == KindBranch);
         last_tgt_d    = issue_tgt;
         cnt_d         = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      end
   end

   assign imem_addr_o    = pc_i;
   assign pc_target_o    = issue ? issue_tgt : last_tgt_q;
   assign epc_o          = epc_q;
   assign redirect_cnt_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StBoot;
         boot_cnt_q  <= '0;
         pend_kind_q <= KindNone;
         pend_tgt_q  <= '0;
         epc_q       <= '0;
         last_tgt_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         pend_kind_q <= pend_kind_d;
         pend_tgt_q  <= pend_tgt_d;
         epc_q       <= epc_d;
         last_tgt_q  <= last_tgt_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, checked against a
// rank-based behavioural model; the bench also plays the role of the program counter.
module tb_fetch_controller;

   localparam logic [31:0] Trap   = 32'h0000_0100;
   localparam int          Boot   = 4;
   localparam int          CntW   = 4;
   localparam int          CntMax = 15;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     pc = '0;
   logic            hazard = 1'b0, br = 1'b0, jmp = 1'b0, exc = 1'b0, ready = 1'b0;
   logic [31:0]     br_tgt = '0, jmp_tgt = '0, exc_pc = '0;
   logic            imem_req, pc_stall, pc_redirect, flush_if, flush_id;
   logic [31:0]     imem_addr, pc_target, epc;
   logic [CntW-1:0] redirect_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: boot cycles left, drain flag, pending rank (0 none,1 jump,2 branch,3 exc).
   int          m_boot = Boot, m_pend_rank = 0, m_cnt = 0;
   bit          m_drain = 1'b0;
   logic [31:0] m_pend_tgt = '0, m_epc = '0, m_last = '0;

   int          e_new_rank, e_sel_rank, e_rank;
   logic [31:0] e_new_tgt, e_sel_tgt, e_itgt, e_tgt;
   logic        e_req, e_stall, e_redir, e_fif, e_fid;

   fetch_controller #(
      .TRAP_VECTOR(Trap),
      .BOOT_CYCLES(Boot),
      .CNT_W      (CntW)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .pc_i              (pc),
      .hazard_stall_i    (hazard),
      .ex_branch_taken_i (br),
      .ex_branch_target_i(br_tgt),
      .id_jump_i         (jmp),
      .id_jump_target_i  (jmp_tgt),
      .exc_req_i         (exc),
      .exc_pc_i          (exc_pc),
      .imem_ready_i      (ready),
      .imem_req_o        (imem_req),
      .imem_addr_o       (imem_addr),
      .pc_stall_o        (pc_stall),
      .pc_redirect_o     (pc_redirect),
      .pc_target_o       (pc_target),
      .flush_if_o        (flush_if),
      .flush_id_o        (flush_id),
      .epc_o             (epc),
      .redirect_cnt_o    (redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      e_new_rank = exc ? 3 : br ? 2 : jmp ? 1 : 0;
      e_new_tgt  = exc ? Trap : br ? br_tgt : jmp ? jmp_tgt : 32'h0;
      e_sel_rank = (e_new_rank > m_pend_rank) ? e_new_rank : m_pend_rank;
      e_sel_tgt  = (e_new_rank > m_pend_rank) ? e_new_tgt : m_pend_tgt;
      e_req = 1'b0; e_stall = 1'b1; e_redir = 1'b0; e_fif = 1'b0; e_fid = 1'b0;
      e_tgt = m_last; e_rank = 0; e_itgt = '0;
      if (m_boot == 0 && !m_drain) begin
         e_req = 1'b1;
         if (e_new_rank > 0 && ready) begin
            e_rank = e_new_rank;
            e_itgt = e_new_tgt;
         end else if (e_new_rank == 0) begin
            e_stall = !ready || hazard;
         end
      end else if (m_boot == 0) begin
         e_req = 1'b1;
         if (ready) begin
            e_rank = e_sel_rank;
            e_itgt = e_sel_tgt;
         end
      end
      if (e_rank > 0) begin
         e_redir = 1'b1;
         e_stall = 1'b0;
         e_tgt   = e_itgt;
         e_fif   = 1'b1;
         e_fid   = (e_rank >= 2);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_boot = Boot; m_drain = 1'b0; m_pend_rank = 0; m_epc = '0; m_last = '0; m_cnt = 0;
      end else if (m_boot > 0) begin
         m_boot--;
      end else begin
         if (exc && (!m_drain || m_pend_rank < 3)) m_epc = exc_pc;
         if (e_rank > 0) begin
            m_cnt       = (m_cnt < CntMax) ? m_cnt + 1 : CntMax;
            m_last      = e_itgt;
            m_drain     = 1'b0;
            m_pend_rank = 0;
         end else if (!m_drain && e_new_rank > 0) begin
            m_drain     = 1'b1;
            m_pend_rank = e_new_rank;
            m_pend_tgt  = e_new_tgt;
         end else if (m_drain) begin
            m_pend_rank = e_sel_rank;
            m_pend_tgt  = e_sel_tgt;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
      if (!rst) begin
         chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
         chk("imem_addr", imem_addr, pc);
         chk("pc_stall", {31'b0, pc_stall}, {31'b0, e_stall});
         chk("pc_redirect", {31'b0, pc_redirect}, {31'b0, e_redir});
         chk("pc_target", pc_target, e_tgt);
         chk("flush_if", {31'b0, flush_if}, {31'b0, e_fif});
         chk("flush_id", {31'b0, flush_id}, {31'b0, e_fid});
         chk("epc", epc, m_epc);
         chk("redirect_cnt", {28'b0, redirect_cnt}, m_cnt);
      end
   endtask

   task automatic tick();
      logic        r, s;
      logic [31:0] t;
      r = pc_redirect; s = pc_stall; t = pc_target;
      @(posedge clk);
      model_update();
      if (rst) pc = '0;
      else if (r) pc = t;
      else if (!s) pc = pc + 32'd4;
      #1;
   endtask

   task automatic clear_req();
      br = 1'b0; jmp = 1'b0; exc = 1'b0; hazard = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      // Reset and boot
      rst = 1'b1; ready = 1'b0;
      repeat (2) begin settle(); tick(); end
      rst = 1'b0; ready = 1'b1;
      for (int i = 0; i < Boot; i++) begin
         settle(); chk("t1_boot_req_low", {31'b0, imem_req}, 32'd0); tick();
      end
      settle(); chk("t1_req_high", {31'b0, imem_req}, 32'd1); chk("t1_pc0", pc, 32'h0); tick();
      settle(); chk("t1_pc4", pc, 32'h4); tick();
      settle(); chk("t1_pc8", pc, 32'h8);
      // Branch redirect issued same cycle
      br = 1'b1; br_tgt = 32'h40;
      settle();
      chk("t2_redirect", {31'b0, pc_redirect}, 32'd1);
      chk("t2_target", pc_target, 32'h40);
      chk("t2_flush_id", {31'b0, flush_id}, 32'd1);
      tick(); clear_req();
      settle(); chk("t2_pc", pc, 32'h40); chk("t2_cnt", {28'b0, redirect_cnt}, 32'd1);
      // Jump and branch together: branch wins
      br = 1'b1; br_tgt = 32'h40; jmp = 1'b1; jmp_tgt = 32'h80;
      settle(); chk("t3_target", pc_target, 32'h40); chk("t3_flush_id", {31'b0, flush_id}, 32'd1);
      tick(); clear_req();
      // Jump parked in drain, then exception overrides it
      ready = 1'b0; jmp = 1'b1; jmp_tgt = 32'h80;
      settle(); chk("t4_stall_a", {31'b0, pc_stall}, 32'd1); tick(); clear_req();
      exc = 1'b1; exc_pc = 32'h1C;
      settle(); chk("t4_stall_b", {31'b0, pc_stall}, 32'd1); tick(); clear_req();
      settle(); chk("t4_no_redirect", {31'b0, pc_redirect}, 32'd0); tick();
      ready = 1'b1;
      settle();
      chk("t4_target", pc_target, 32'h100);
      chk("t4_epc", epc, 32'h1C);
      chk("t4_flush_if", {31'b0, flush_if}, 32'd1);
      chk("t4_flush_id", {31'b0, flush_id}, 32'd1);
      tick();
      // Load-use stall holds the PC
      hazard = 1'b1;
      settle(); chk("t5_stall", {31'b0, pc_stall}, 32'd1); held = pc; tick();
      settle(); chk("t5_pc_held", pc, held); chk("t5_addr_repeat", imem_addr, held);
      tick(); clear_req();
      // Redirect counter saturates
      for (int i = 0; i < 20; i++) begin
         br = 1'b1; br_tgt = 32'h300 + 32'(i * 4);
         settle(); tick();
      end
      clear_req();
      settle(); chk("cnt_saturated", {28'b0, redirect_cnt}, CntMax);
      // Reset while a branch is pending in drain
      ready = 1'b0; br = 1'b1; br_tgt = 32'h200;
      settle(); tick(); clear_req();
      rst = 1'b1;
      settle(); tick();
      rst = 1'b0;
      settle();
      chk("t6_req", {31'b0, imem_req}, 32'd0);
      chk("t6_stall", {31'b0, pc_stall}, 32'd1);
      chk("t6_redirect", {31'b0, pc_redirect}, 32'd0);
      chk("t6_target", pc_target, 32'h0);
      chk("t6_epc", epc, 32'h0);
      chk("t6_cnt", {28'b0, redirect_cnt}, 32'd0);
      tick();
      // Random traffic
      for (int i = 0; i < 800; i++) begin
         rst     = ($urandom_range(63) == 0);
         ready   = ($urandom_range(3) != 0);
         hazard  = ($urandom_range(3) == 0);
         br      = ($urandom_range(7) == 0);
         jmp     = ($urandom_range(7) == 0);
         exc     = ($urandom_range(15) == 0);
         br_tgt  = $urandom() & 32'hFFFF_FFFC;
         jmp_tgt = $urandom() & 32'hFFFF_FFFC;
         exc_pc  = $urandom() & 32'hFFFF_FFFC;
         settle(); tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
